taxi_axil_reg_if_rd: RTL and testbench

- AXI4-Lite read slave that turns each AR transaction into a single-word read on a simple register interface: address, enable, data, wait, ack.
- Sits directly downstream of the AXI-lite read width adapter and interconnect. It is the endpoint that lets CSR blocks be read without each block implementing AXI handshakes.
- Includes a bounded timeout, so an unresponsive register block cannot hang the bus.

---
 rtl/taxi_axil_pkg.sv | 16 +
 rtl/taxi_axil_if.sv | 31 +++
 rtl/taxi_axil_reg_if_rd.sv | 143 ++++++++++++++
 tb/tb_taxi_axil_reg_if_rd.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_axil_pkg.sv
// Purpose: shared AXI4-Lite definitions (response codes, register-interface FSM states).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package taxi_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [0:0] {
        STATE_IDLE   = 1'b0,
        STATE_ACCESS = 1'b1
    } state_t;

endpackage

// File: rtl/taxi_axil_if.sv
// Purpose: AXI4-Lite read channel bundle (AR, R) with slave/master views.
// Latency: n/a (wiring only).
// Backpressure: standard valid/ready on AR and R.
interface taxi_axil_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int STRB_W   = DATA_W/8,
    parameter int ARUSER_W = 1,
    parameter int RUSER_W  = 1
);
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic [ARUSER_W-1:0] aruser;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic [RUSER_W-1:0]  ruser;
    logic                rvalid;
    logic                rready;

    modport rd_slv (
        input  araddr, arprot, aruser, arvalid, rready,
        output arready, rdata, rresp, ruser, rvalid
    );

    modport rd_mst (
        output araddr, arprot, aruser, arvalid, rready,
        input  arready, rdata, rresp, ruser, rvalid
    );
endinterface

// File: rtl/taxi_axil_reg_if_rd.sv
// Purpose: AXI4-Lite read slave bridging each AR beat to one word read on a simple register port.
// Latency: AR handshake at N -> reg_rd_en from N+1 -> ack at N+1 gives rvalid at N+2 (3-cycle read period).
// Backpressure: no new AR accepted while an R beat is pending; R held stable until rready.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   s_axil_rd         - AXI4-Lite read slave (AR, R); ARUSER ignored, RUSER driven 0
//   reg_rd_addr       - word-aligned read address (registered)
//   reg_rd_en         - read strobe, held until ack or timeout
//   reg_rd_data       - read data, captured on ack
//   reg_rd_wait       - stretches the access and freezes the timeout counter
//   reg_rd_ack        - access complete, reg_rd_data valid this cycle
//
// Option: define TAXI_AXIL_REG_IF_RD_SLVERR_EN to answer timed-out reads with SLVERR
// instead of OKAY (rdata is zero either way).
module taxi_axil_reg_if_rd
    import taxi_axil_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    taxi_axil_if.rd_slv                   s_axil_rd,
    output logic [s_axil_rd.ADDR_W-1:0]   reg_rd_addr,
    output logic                          reg_rd_en,
    input  logic [s_axil_rd.DATA_W-1:0]   reg_rd_data,
    input  logic                          reg_rd_wait,
    input  logic                          reg_rd_ack
);

    localparam int DATA_W  = s_axil_rd.DATA_W;
    localparam int ADDR_W  = s_axil_rd.ADDR_W;
    localparam int STRB_W  = s_axil_rd.STRB_W;
    localparam int RUSER_W = s_axil_rd.RUSER_W;

    // Counter must hold TIMEOUT-1; keep at least one bit so TIMEOUT=0 still elaborates.
    localparam int CNT_W = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    // Clears the byte-offset bits so the register block only ever sees word addresses.
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(STRB_W - 1);

`ifdef TAXI_AXIL_REG_IF_RD_SLVERR_EN
    localparam logic [1:0] TIMEOUT_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] TIMEOUT_RESP = RESP_OKAY;
`endif

    state_t              state_q, state_d;
    logic                arready_q, arready_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    // Protection and user sideband carry no meaning for a register read.
    logic unused_ok;
    assign unused_ok = ^{s_axil_rd.arprot, s_axil_rd.aruser};

    always_comb begin
        state_d   = state_q;
        arready_d = 1'b0;
        rvalid_d  = rvalid_q && !s_axil_rd.rready;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        addr_d    = addr_q;
        en_d      = en_q;
        cnt_d     = cnt_q;

        case (state_q)
            STATE_IDLE: begin
                // Accept AR only once any pending R beat is gone (or leaving this cycle).
                arready_d = !(rvalid_q && !s_axil_rd.rready);
                if (arready_q && s_axil_rd.arvalid) begin
                    addr_d    = s_axil_rd.araddr & ADDR_MASK;
                    en_d      = 1'b1;
                    cnt_d     = CNT_INIT;
                    arready_d = 1'b0;
                    state_d   = STATE_ACCESS;
                end
            end

            STATE_ACCESS: begin
                // Ack has priority over both wait and timeout.
                if (reg_rd_ack) begin
                    rdata_d  = reg_rd_data;
                    rresp_d  = RESP_OKAY;
                    rvalid_d = 1'b1;
                    en_d     = 1'b0;
                    state_d  = STATE_IDLE;
                end else if (reg_rd_wait) begin
                    cnt_d = cnt_q;
                end else if (TIMEOUT != 0 && cnt_q == '0) begin
                    rdata_d  = '0;
                    rresp_d  = TIMEOUT_RESP;
                    rvalid_d = 1'b1;
                    en_d     = 1'b0;
                    state_d  = STATE_IDLE;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = STATE_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STATE_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            addr_q    <= '0;
            en_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            addr_q    <= addr_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
        end
    end

    assign s_axil_rd.arready = arready_q;
    assign s_axil_rd.rvalid  = rvalid_q;
    assign s_axil_rd.rdata   = rdata_q;
    assign s_axil_rd.rresp   = rresp_q;
    assign s_axil_rd.ruser   = RUSER_W'(0);
    assign reg_rd_addr       = addr_q;
    assign reg_rd_en         = en_q;

endmodule

// File: tb/tb_taxi_axil_reg_if_rd.sv
// Purpose: directed self-checking bench for taxi_axil_reg_if_rd (TIMEOUT=4, 16-bit addr, 32-bit data).
// Latency: n/a.
// Backpressure: exercises rready stalls with a second AR waiting.
module tb_taxi_axil_reg_if_rd;
    import taxi_axil_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] reg_rd_addr;
    logic        reg_rd_en;
    logic [31:0] reg_rd_data = '0;
    logic        reg_rd_wait = 1'b0;
    logic        reg_rd_ack  = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

`ifdef TAXI_AXIL_REG_IF_RD_SLVERR_EN
    localparam logic [1:0] EXP_TO_RESP = 2'b10;
`else
    localparam logic [1:0] EXP_TO_RESP = 2'b00;
`endif

    taxi_axil_if #(.DATA_W(32), .ADDR_W(16)) axil ();

    taxi_axil_reg_if_rd #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .s_axil_rd   (axil),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .reg_rd_wait (reg_rd_wait),
        .reg_rd_ack  (reg_rd_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present AR and return in the first cycle after the handshake edge.
    task automatic ar_handshake(input logic [15:0] addr, input string tag);
        int budget;
        budget = 20;
        axil.araddr  = addr;
        axil.arvalid = 1'b1;
        while (!axil.arready && budget > 0) begin
            tick();
            budget--;
        end
        check({tag, "_arready"}, 32'(axil.arready), 32'd1);
        tick();
        axil.arvalid = 1'b0;
    endtask

    // Pulse rready for one cycle to drain the R beat.
    task automatic drain_r();
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
    endtask

    initial begin
        int cnt;
        axil.araddr  = '0;
        axil.arprot  = '0;
        axil.aruser  = '0;
        axil.arvalid = 1'b0;
        axil.rready  = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_arready", 32'(axil.arready), 32'd0);
        check("rst_rvalid",  32'(axil.rvalid),  32'd0);
        check("rst_rdata",   axil.rdata,        32'd0);
        check("rst_rresp",   32'(axil.rresp),   32'd0);
        check("rst_ruser",   32'(axil.ruser),   32'd0);
        check("rst_en",      32'(reg_rd_en),    32'd0);
        check("rst_addr",    32'(reg_rd_addr),  32'd0);
        rst = 1'b0;
        tick();
        check("idle_arready", 32'(axil.arready), 32'd1);

        // Basic read, ack in first enable cycle
        ar_handshake(16'h1004, "basic");
        check("basic_en1",    32'(reg_rd_en),   32'd1);
        check("basic_addr",   32'(reg_rd_addr), 32'h1004);
        check("basic_rv0",    32'(axil.rvalid), 32'd0);
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'hDEADBEEF;
        tick();
        reg_rd_ack = 1'b0;
        check("basic_en_off", 32'(reg_rd_en),   32'd0);
        check("basic_rvalid", 32'(axil.rvalid), 32'd1);
        check("basic_rdata",  axil.rdata,       32'hDEADBEEF);
        check("basic_rresp",  32'(axil.rresp),  32'd0);
        check("basic_ruser",  32'(axil.ruser),  32'd0);
        check("basic_ar_busy", 32'(axil.arready), 32'd0);
        drain_r();
        check("basic_rv_clr", 32'(axil.rvalid),  32'd0);
        check("basic_ar_back", 32'(axil.arready), 32'd1);

        // Unaligned address
        ar_handshake(16'h1007, "unal");
        check("unal_addr", 32'(reg_rd_addr), 32'h1004);
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'h0BADF00D;
        tick();
        reg_rd_ack = 1'b0;
        check("unal_rdata", axil.rdata, 32'h0BADF00D);
        drain_r();

        // Timeout: never ack
        ar_handshake(16'h2000, "to");
        cnt = 0;
        while (reg_rd_en && cnt < 10) begin
            cnt++;
            tick();
        end
        check("to_en_cycles", 32'(cnt),          32'd4);
        check("to_rvalid",    32'(axil.rvalid),  32'd1);
        check("to_rdata",     axil.rdata,        32'd0);
        check("to_rresp",     32'(axil.rresp),   32'(EXP_TO_RESP));
        check("to_arready",   32'(axil.arready), 32'd0);
        drain_r();

        // Wait held 20 cycles, then ack together with wait
        ar_handshake(16'h2004, "wait");
        reg_rd_wait = 1'b1;
        repeat (20) tick();
        check("wait_en_held", 32'(reg_rd_en),   32'd1);
        check("wait_no_rv",   32'(axil.rvalid), 32'd0);
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'h12345678;
        tick();
        reg_rd_ack  = 1'b0;
        reg_rd_wait = 1'b0;
        check("wait_rvalid", 32'(axil.rvalid), 32'd1);
        check("wait_rdata",  axil.rdata,       32'h12345678);
        check("wait_rresp",  32'(axil.rresp),  32'd0);
        drain_r();

        // Backpressure with second AR pending
        ar_handshake(16'h3000, "bp");
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'hCAFEF00D;
        tick();
        reg_rd_ack   = 1'b0;
        axil.araddr  = 16'h3008;
        axil.arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid",  32'(axil.rvalid),  32'd1);
            check("bp_rdata",   axil.rdata,        32'hCAFEF00D);
            check("bp_rresp",   32'(axil.rresp),   32'd0);
            check("bp_arready", 32'(axil.arready), 32'd0);
            check("bp_en",      32'(reg_rd_en),    32'd0);
            tick();
        end
        axil.rready = 1'b1;
        tick();
        axil.rready = 1'b0;
        check("bp_rv_clr",   32'(axil.rvalid),  32'd0);
        check("bp_ar_back",  32'(axil.arready), 32'd1);
        check("bp_en_still", 32'(reg_rd_en),    32'd0);
        tick();
        axil.arvalid = 1'b0;
        check("bp2_en",   32'(reg_rd_en),   32'd1);
        check("bp2_addr", 32'(reg_rd_addr), 32'h3008);
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'h11112222;
        tick();
        reg_rd_ack = 1'b0;
        check("bp2_rdata", axil.rdata, 32'h11112222);
        drain_r();

        // Reset during ACCESS, late ack ignored
        ar_handshake(16'h4000, "rstm");
        check("rstm_en1", 32'(reg_rd_en), 32'd1);
        rst = 1'b1;
        tick();
        check("rstm_en0",    32'(reg_rd_en),    32'd0);
        check("rstm_rv0",    32'(axil.rvalid),  32'd0);
        check("rstm_ar0",    32'(axil.arready), 32'd0);
        rst         = 1'b0;
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'hFFFF0000;
        tick();
        tick();
        check("rstm_late_rv", 32'(axil.rvalid),  32'd0);
        check("rstm_late_en", 32'(reg_rd_en),    32'd0);
        check("rstm_ar1",     32'(axil.arready), 32'd1);
        reg_rd_ack = 1'b0;
        ar_handshake(16'h4010, "rstm_new");
        check("rstm_new_en",   32'(reg_rd_en),   32'd1);
        check("rstm_new_addr", 32'(reg_rd_addr), 32'h4010);
        reg_rd_ack  = 1'b1;
        reg_rd_data = 32'h55AA55AA;
        tick();
        reg_rd_ack = 1'b0;
        check("rstm_new_rv",    32'(axil.rvalid), 32'd1);
        check("rstm_new_rdata", axil.rdata,       32'h55AA55AA);
        check("rstm_new_rresp", 32'(axil.rresp),  32'd0);
        drain_r();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
